// File: rtl/ac_pkg.sv
// Shared Aho-Corasick definitions: default widths, root index, walker FSM
// encoding and the layout of a goto-RAM word. Also used by the RAM wrappers
// and the downstream output decoder.
package ac_pkg;

    localparam int AC_STATE_W        = 8;
    localparam int AC_CHAR_W         = 8;
    localparam int AC_ROOT_STATE     = 0;
    localparam int AC_MAX_FAIL_STEPS = 31;

    // Goto-RAM word: [GOTO_HIT_BIT] = hit flag, [GOTO_HIT_BIT-1:0] = next state
    localparam int GOTO_HIT_BIT      = AC_STATE_W;

    typedef enum logic [1:0] {
        WALK_IDLE   = 2'd0,
        WALK_G_WAIT = 2'd1,
        WALK_F_WAIT = 2'd2
    } walk_state_t;

endpackage

// File: rtl/ac_failure_walker.sv
// Aho-Corasick transition controller. Takes one character at a time, probes
// the goto RAM with {state,char} and on a miss follows failure links through
// the failure RAM until a goto hit, the root, or the per-character step limit.
//
// Handshake: a character is accepted in any cycle where CHAR_VALID and
// CHAR_READY are both high; CHAR_READY is high only while the FSM is idle and
// CHAR_DATA is sampled only in the accept cycle. Both RAMs are synchronous:
// the strobe is driven combinationally in the cycle the walker decides to read,
// and the data is consumed in the following cycle.
module ac_failure_walker
    import ac_pkg::*;
#(
    parameter int STATE_W        = AC_STATE_W,
    parameter int CHAR_W         = AC_CHAR_W,
    parameter int ROOT_STATE     = AC_ROOT_STATE,
    parameter int MAX_FAIL_STEPS = AC_MAX_FAIL_STEPS
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CHAR_VALID,
    output logic                      CHAR_READY,
    input  logic [CHAR_W-1:0]         CHAR_DATA,
    output logic                      GOTO_RD,
    output logic [STATE_W+CHAR_W-1:0] GOTO_ADDR,
    input  logic [STATE_W:0]          GOTO_DATA,
    output logic                      FAIL_RD,
    output logic [STATE_W-1:0]        FAIL_ADDR,
    input  logic [STATE_W-1:0]        FAIL_DATA,
    output logic                      STATE_VALID,
    output logic [STATE_W-1:0]        CUR_STATE,
    output logic                      WALK_ERR
);

    localparam int                 STEP_W   = $clog2(MAX_FAIL_STEPS + 1);
    localparam logic [STEP_W-1:0]  STEP_MAX = STEP_W'(MAX_FAIL_STEPS);
    localparam logic [STEP_W-1:0]  STEP_ONE = STEP_W'(1);
    localparam logic [STATE_W-1:0] ROOT     = STATE_W'(ROOT_STATE);

    walk_state_t         fsm_state;
    logic [STATE_W-1:0]  cur_state_q;
    logic [CHAR_W-1:0]   char_q;
    logic [STEP_W-1:0]   step_q;
    logic                state_valid_q;
    logic                walk_err_q;

    logic                accept;
    logic                goto_hit;
    logic                at_root;
    logic [STEP_W-1:0]   step_inc;
    logic                step_limit;

    assign CHAR_READY  = (fsm_state == WALK_IDLE);
    assign STATE_VALID = state_valid_q;
    assign CUR_STATE   = cur_state_q;
    assign WALK_ERR    = walk_err_q;

    // Decode RAM strobes/addresses from the FSM state and the returning RAM data
    always_comb begin
        accept     = CHAR_VALID & CHAR_READY;
        goto_hit   = GOTO_DATA[STATE_W];
        at_root    = (cur_state_q == ROOT);
        step_inc   = (step_q == STEP_MAX) ? step_q : step_q + STEP_ONE;
        step_limit = (step_inc == STEP_MAX);
        GOTO_RD    = 1'b0;
        GOTO_ADDR  = '0;
        FAIL_RD    = 1'b0;
        FAIL_ADDR  = '0;
        if (!RST) begin
            case (fsm_state)
                WALK_IDLE: begin
                    if (accept) begin
                        GOTO_RD   = 1'b1;
                        GOTO_ADDR = {cur_state_q, CHAR_DATA};
                    end
                end
                WALK_G_WAIT: begin
                    if (!goto_hit && !at_root) begin
                        FAIL_RD   = 1'b1;
                        FAIL_ADDR = cur_state_q;
                    end
                end
                WALK_F_WAIT: begin
                    if (!step_limit) begin
                        GOTO_RD   = 1'b1;
                        GOTO_ADDR = {FAIL_DATA, char_q};
                    end
                end
                default: ;
            endcase
        end
    end

    // Walker FSM: accept, resolve goto result, follow failure links, flag step overrun
    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_state     <= WALK_IDLE;
            cur_state_q   <= ROOT;
            char_q        <= '0;
            step_q        <= '0;
            state_valid_q <= 1'b0;
            walk_err_q    <= 1'b0;
        end else begin
            state_valid_q <= 1'b0;
            case (fsm_state)
                WALK_IDLE: begin
                    if (accept) begin
                        char_q    <= CHAR_DATA;
                        step_q    <= '0;
                        fsm_state <= WALK_G_WAIT;
                    end
                end
                WALK_G_WAIT: begin
                    if (goto_hit) begin
                        cur_state_q   <= GOTO_DATA[STATE_W-1:0];
                        state_valid_q <= 1'b1;
                        fsm_state     <= WALK_IDLE;
                    end else if (at_root) begin
                        // Root has an implicit self-loop on every missing character
                        state_valid_q <= 1'b1;
                        fsm_state     <= WALK_IDLE;
                    end else begin
                        fsm_state <= WALK_F_WAIT;
                    end
                end
                WALK_F_WAIT: begin
                    step_q <= step_inc;
                    if (step_limit) begin
                        cur_state_q   <= ROOT;
                        walk_err_q    <= 1'b1;
                        state_valid_q <= 1'b1;
                        fsm_state     <= WALK_IDLE;
                    end else begin
                        cur_state_q <= FAIL_DATA;
                        fsm_state   <= WALK_G_WAIT;
                    end
                end
                default: fsm_state <= WALK_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ac_failure_walker.sv
// Bench for ac_failure_walker with behavioural goto/failure RAMs. Driver tasks
// push the expected {latency, failure reads, WALK_ERR, CUR_STATE} for every
// character; an independent monitor pops and compares on each STATE_VALID.
module tb_ac_failure_walker;

    localparam int W = 25;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CHAR_VALID = 1'b0;
    logic        CHAR_READY;
    logic [7:0]  CHAR_DATA = 8'h00;
    logic        GOTO_RD;
    logic [15:0] GOTO_ADDR;
    logic [8:0]  GOTO_DATA = 9'h000;
    logic        FAIL_RD;
    logic [7:0]  FAIL_ADDR;
    logic [7:0]  FAIL_DATA = 8'h00;
    logic        STATE_VALID;
    logic [7:0]  CUR_STATE;
    logic        WALK_ERR;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fail_cnt = 0;
    logic [7:0] tb_state = 8'h00;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];

    logic [8:0] goto_mem [logic [15:0]];
    logic [7:0] fail_mem [logic [7:0]];

    ac_failure_walker #(
        .STATE_W(8),
        .CHAR_W(8),
        .ROOT_STATE(0),
        .MAX_FAIL_STEPS(3)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .CHAR_VALID(CHAR_VALID),
        .CHAR_READY(CHAR_READY),
        .CHAR_DATA(CHAR_DATA),
        .GOTO_RD(GOTO_RD),
        .GOTO_ADDR(GOTO_ADDR),
        .GOTO_DATA(GOTO_DATA),
        .FAIL_RD(FAIL_RD),
        .FAIL_ADDR(FAIL_ADDR),
        .FAIL_DATA(FAIL_DATA),
        .STATE_VALID(STATE_VALID),
        .CUR_STATE(CUR_STATE),
        .WALK_ERR(WALK_ERR)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- RAM models ----------------
    always @(posedge CLK) begin
        if (GOTO_RD) GOTO_DATA <= goto_mem.exists(GOTO_ADDR) ? goto_mem[GOTO_ADDR] : 9'h000;
        if (FAIL_RD) FAIL_DATA <= fail_mem.exists(FAIL_ADDR) ? fail_mem[FAIL_ADDR] : 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- accept recorder ----------------
    initial begin
        forever begin
            @(posedge CLK);
            if (RST) acc_q.delete();
            else if (CHAR_VALID && CHAR_READY) acc_q.push_back(cyc);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        int lat;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST) fail_cnt = 0;
            else if (FAIL_RD) fail_cnt++;
            if (STATE_VALID) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_state_valid: got CUR_STATE=0x%0h with nothing expected (cycle %0d)", CUR_STATE, cyc);
                end else begin
                    e = exp_q.pop_front();
                    lat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : 255;
                    chk("cur_state", {24'h0, CUR_STATE}, {24'h0, e[7:0]});
                    chk("walk_err", {31'h0, WALK_ERR}, {31'h0, e[8]});
                    chk("fail_reads", fail_cnt, {24'h0, e[16:9]});
                    chk("latency", lat, {24'h0, e[24:17]});
                end
                fail_cnt = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge CLK);
        while (!CHAR_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        ok = CHAR_READY;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got CHAR_READY=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic send(input logic [7:0] ch, input logic [7:0] exp_state, input logic exp_err,
                        input int exp_lat, input int exp_nfail, output int acc_cyc);
        bit ok;
        acc_cyc = -1;
        wait_ready(ok);
        if (ok) begin
            CHAR_VALID = 1'b1;
            CHAR_DATA  = ch;
            #1;
            chk("goto_probe", {15'h0, GOTO_RD, GOTO_ADDR}, {15'h0, 1'b1, tb_state, ch});
            exp_q.push_back({8'(exp_lat), 8'(exp_nfail), exp_err, exp_state});
            @(posedge CLK);
            acc_cyc = cyc;
            #1;
            CHAR_VALID = 1'b0;
            CHAR_DATA  = 8'($urandom_range(0, 255));
            tb_state   = exp_state;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0, a1, a2, dummy, n;
        bit ok;

        goto_mem[16'h0068] = {1'b1, 8'd5};
        goto_mem[16'h0265] = {1'b1, 8'd9};
        goto_mem[16'h0061] = {1'b1, 8'd1};
        goto_mem[16'h0162] = {1'b1, 8'd2};
        goto_mem[16'h0263] = {1'b1, 8'd3};
        fail_mem[8'd5] = 8'd2;
        fail_mem[8'd9] = 8'd4;
        fail_mem[8'd4] = 8'd6;
        fail_mem[8'd6] = 8'd9;

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_cur_state", {24'h0, CUR_STATE}, 32'h0);
        chk("rst_char_ready", {31'h0, CHAR_READY}, 32'h1);
        chk("rst_goto_rd", {31'h0, GOTO_RD}, 32'h0);
        chk("rst_fail_rd", {31'h0, FAIL_RD}, 32'h0);
        chk("rst_state_valid", {31'h0, STATE_VALID}, 32'h0);
        chk("rst_walk_err", {31'h0, WALK_ERR}, 32'h0);

        // miss at root, hit, one failure hop, step limit, sticky error
        send(8'h7A, 8'd0, 1'b0, 2, 0, dummy);
        send(8'h68, 8'd5, 1'b0, 2, 0, dummy);
        send(8'h65, 8'd9, 1'b0, 4, 1, dummy);
        send(8'h11, 8'd0, 1'b1, 7, 3, dummy);
        send(8'h11, 8'd0, 1'b1, 2, 0, dummy);
        send(8'h68, 8'd5, 1'b1, 2, 0, dummy);

        // reset while waiting on the failure RAM
        wait_ready(ok);
        if (ok) begin
            CHAR_VALID = 1'b1;
            CHAR_DATA  = 8'h65;
            @(posedge CLK);
            #1 CHAR_VALID = 1'b0;
            @(posedge CLK);
            #1 RST = 1'b1;
            @(posedge CLK);
            #1 RST = 1'b0;
            tb_state = 8'h00;
            @(negedge CLK);
            chk("midwalk_rst_cur_state", {24'h0, CUR_STATE}, 32'h0);
            chk("midwalk_rst_walk_err", {31'h0, WALK_ERR}, 32'h0);
            chk("midwalk_rst_ready", {31'h0, CHAR_READY}, 32'h1);
            chk("midwalk_rst_no_valid", {31'h0, STATE_VALID}, 32'h0);
            @(negedge CLK);
            chk("midwalk_rst_no_valid_late", {31'h0, STATE_VALID}, 32'h0);
        end

        // back-to-back hits at peak throughput
        send(8'h61, 8'd1, 1'b0, 2, 0, a0);
        send(8'h62, 8'd2, 1'b0, 2, 0, a1);
        send(8'h63, 8'd3, 1'b0, 2, 0, a2);
        chk("b2b_spacing_1", a1 - a0, 32'd2);
        chk("b2b_spacing_2", a2 - a1, 32'd2);

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
